// File: rtl/plic_gw.sv
// plic_gw: parametrised PLIC with per-source gateways and claim/complete, on an AXI4-Lite slave.
// Define PLIC_GW_EDGE_EN to add per-source edge-triggered mode (trigger-type register at 0x1080).
module plic_gw #(
  parameter int NSRC   = 32,
  parameter int NCTX   = 2,
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC-1:0]   src_i,
  output logic [NCTX-1:0]   irq_o,
  input  logic [27:0]       s_axi_awaddr_i,
  input  logic              s_axi_awvalid_i,
  output logic              s_axi_awready_o,
  input  logic [31:0]       s_axi_wdata_i,
  input  logic              s_axi_wvalid_i,
  output logic              s_axi_wready_o,
  output logic [1:0]        s_axi_bresp_o,
  output logic              s_axi_bvalid_o,
  input  logic              s_axi_bready_i,
  input  logic [27:0]       s_axi_araddr_i,
  input  logic              s_axi_arvalid_i,
  output logic              s_axi_arready_o,
  output logic [31:0]       s_axi_rdata_o,
  output logic [1:0]        s_axi_rresp_o,
  output logic              s_axi_rvalid_o,
  input  logic              s_axi_rready_i
);
  localparam int IDW   = $clog2(NSRC);
  localparam int CTXW  = (NCTX > 1) ? $clog2(NCTX) : 1;
  localparam int NWORD = (NSRC + 31) / 32;

  typedef enum logic [1:0] {GW_IDLE, GW_PEND, GW_CLAIMED} gw_e;
  typedef enum logic [2:0] {R_NONE, R_PRIO, R_PEND, R_TRIG, R_EN, R_THR, R_CLAIM} reg_e;
  typedef struct packed {
    reg_e        kind;
    logic [31:0] idx;
    logic [31:0] ctx;
  } dec_t;

  function automatic dec_t decode(input logic [27:0] addr);
    logic [25:0] off;
    dec_t d;
    off    = addr[25:0];
    d.kind = R_NONE;
    d.idx  = 32'(off[11:2]);
    d.ctx  = '0;
    if (off < 26'h1000) begin
      if (d.idx < NSRC) d.kind = R_PRIO;
    end else if (off < 26'h1100) begin
      d.idx = 32'(off[6:2]);
      if (d.idx < NWORD) d.kind = (off < 26'h1080) ? R_PEND : R_TRIG;
    end else if (off >= 26'h2000 && off < 26'h200000) begin
      d.ctx = 32'((off - 26'h2000) >> 7);
      d.idx = 32'(off[6:2]);
      if (d.ctx < NCTX && d.idx < NWORD) d.kind = R_EN;
    end else if (off >= 26'h200000) begin
      d.ctx = 32'((off - 26'h200000) >> 12);
      if (d.ctx < NCTX && off[11:0] == 12'h000) d.kind = R_THR;
      else if (d.ctx < NCTX && off[11:0] == 12'h004) d.kind = R_CLAIM;
    end
    return d;
  endfunction

  function automatic logic [31:0] get_word(input logic [NSRC-1:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++)
      if (w * 32 + b < NSRC) r[b] = v[w * 32 + b];
    return r;
  endfunction

  // Source 0 is reserved, so bit 0 of any per-source vector is forced low.
  function automatic logic [NSRC-1:0] put_word(input logic [NSRC-1:0] v, input int w,
                                               input logic [31:0] d);
    logic [NSRC-1:0] r;
    r = v;
    for (int b = 0; b < 32; b++)
      if (w * 32 + b < NSRC) r[w * 32 + b] = d[b];
    r[0] = 1'b0;
    return r;
  endfunction

  gw_e               gw_q   [NSRC];
  logic [PRIO_W-1:0] prio_q [NSRC];
  logic [NSRC-1:0]   en_q   [NCTX];
  logic [PRIO_W-1:0] thr_q  [NCTX];
  logic [IDW-1:0]    best   [NCTX];
  logic [NCTX-1:0]   irq_q;
  logic [NSRC-1:0]   pend, trig, req, reload;

  logic        arready_q, rvalid_q, awready_q, wready_q, bvalid_q;
  logic [31:0] rdata_q, wdata_q, rd_data;
  logic [27:0] awaddr_q;
  dec_t        rd_dec, wr_dec;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, wr_fire, claim_fire, cmpl_fire;
  logic [IDW-1:0] claim_id;
  logic [9:0]     cmpl_id;
  logic           unused_ok;

  assign ar_hs      = s_axi_arvalid_i && arready_q;
  assign r_hs       = rvalid_q && s_axi_rready_i;
  assign aw_hs      = s_axi_awvalid_i && awready_q;
  assign w_hs       = s_axi_wvalid_i && wready_q;
  assign b_hs       = bvalid_q && s_axi_bready_i;
  // Both channels captured and no response pending: commit the write this edge.
  assign wr_fire    = !awready_q && !wready_q && !bvalid_q;
  assign wr_dec     = decode(awaddr_q);
  assign claim_id   = best[rd_dec.ctx[CTXW-1:0]];
  assign claim_fire = ar_hs && (rd_dec.kind == R_CLAIM) && (claim_id != '0);
  assign cmpl_fire  = wr_fire && (wr_dec.kind == R_CLAIM);
  assign cmpl_id    = wdata_q[9:0];
  assign unused_ok  = ^{s_axi_awaddr_i[27:26], s_axi_araddr_i[27:26], src_i[0]};

`ifdef PLIC_GW_EDGE_EN
  logic [NSRC-1:0] trig_q, src_q, rise_q, defer_q;
  assign trig   = trig_q;
  assign req    = (src_i & ~trig_q) | (rise_q & trig_q);
  assign reload = (defer_q | rise_q) & trig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q  <= '0;
      src_q   <= '0;
      rise_q  <= '0;
      defer_q <= '0;
    end else begin
      src_q  <= src_i;
      rise_q <= src_i & ~src_q;
      if (wr_fire && wr_dec.kind == R_TRIG)
        trig_q <= put_word(trig_q, int'(wr_dec.idx), wdata_q);
      for (int i = 1; i < NSRC; i++) begin
        if (cmpl_fire && int'(cmpl_id) == i && gw_q[i] == GW_CLAIMED) defer_q[i] <= 1'b0;
        else if (rise_q[i] && trig_q[i] && gw_q[i] != GW_IDLE) defer_q[i] <= 1'b1;
      end
    end
  end
`else
  assign trig   = '0;
  assign req    = src_i;
  assign reload = '0;
`endif

  always_comb begin
    for (int i = 0; i < NSRC; i++) pend[i] = (gw_q[i] == GW_PEND);
    pend[0] = 1'b0;
  end

  // Threshold seeds the running best, so only strictly higher priorities win and ties keep the lower ID.
  always_comb begin : arb
    logic [PRIO_W-1:0] bp;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    bp = '0;
    for (int c = 0; c < NCTX; c++) begin
      bp      = thr_q[c];
      best[c] = '0;
      for (int i = 1; i < NSRC; i++)
        if (pend[i] && en_q[c][i] && prio_q[i] > bp) begin
          bp      = prio_q[i];
          best[c] = IDW'(i);
        end
    end
  end

  always_comb begin
    rd_dec  = decode(s_axi_araddr_i);
    rd_data = '0;
    case (rd_dec.kind)
      R_PRIO:  rd_data = 32'(prio_q[rd_dec.idx[IDW-1:0]]);
      R_PEND:  rd_data = get_word(pend, int'(rd_dec.idx));
      R_TRIG:  rd_data = get_word(trig, int'(rd_dec.idx));
      R_EN:    rd_data = get_word(en_q[rd_dec.ctx[CTXW-1:0]], int'(rd_dec.idx));
      R_THR:   rd_data = 32'(thr_q[rd_dec.ctx[CTXW-1:0]]);
      R_CLAIM: rd_data = 32'(claim_id);
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register arrays are architectural state with defined reset values, so each entry is reset.
      for (int i = 0; i < NSRC; i++) begin
        gw_q[i]   <= GW_IDLE;
        prio_q[i] <= '0;
      end
      for (int c = 0; c < NCTX; c++) begin
        en_q[c]  <= '0;
        thr_q[c] <= '0;
      end
      irq_q     <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
      for (int c = 0; c < NCTX; c++) irq_q[c] <= (best[c] != '0);

      if (ar_hs) begin
        rdata_q   <= rd_data;
        rvalid_q  <= 1'b1;
        arready_q <= 1'b0;
      end else if (r_hs) begin
        rvalid_q  <= 1'b0;
        arready_q <= 1'b1;
      end

      if (aw_hs) begin
        awaddr_q  <= s_axi_awaddr_i;
        awready_q <= 1'b0;
      end
      if (w_hs) begin
        wdata_q  <= s_axi_wdata_i;
        wready_q <= 1'b0;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        case (wr_dec.kind)
          R_PRIO: if (wr_dec.idx != 0) prio_q[wr_dec.idx[IDW-1:0]] <= wdata_q[PRIO_W-1:0];
          R_EN:   en_q[wr_dec.ctx[CTXW-1:0]] <=
                    put_word(en_q[wr_dec.ctx[CTXW-1:0]], int'(wr_dec.idx), wdata_q);
          R_THR:  thr_q[wr_dec.ctx[CTXW-1:0]] <= wdata_q[PRIO_W-1:0];
          default: ;
        endcase
      end else if (b_hs) begin
        bvalid_q  <= 1'b0;
        awready_q <= 1'b1;
        wready_q  <= 1'b1;
      end

      for (int i = 1; i < NSRC; i++) begin
        case (gw_q[i])
          GW_IDLE:    if (req[i]) gw_q[i] <= GW_PEND;
          GW_PEND:    if (claim_fire && int'(claim_id) == i) gw_q[i] <= GW_CLAIMED;
          GW_CLAIMED: if (cmpl_fire && int'(cmpl_id) == i)
                        gw_q[i] <= reload[i] ? GW_PEND : GW_IDLE;
          default:    gw_q[i] <= GW_IDLE;
        endcase
      end
    end
  end

  assign irq_o           = irq_q;
  assign s_axi_arready_o = arready_q;
  assign s_axi_rvalid_o  = rvalid_q;
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = 2'b00;
  assign s_axi_awready_o = awready_q;
  assign s_axi_wready_o  = wready_q;
  assign s_axi_bvalid_o  = bvalid_q;
  assign s_axi_bresp_o   = 2'b00;

endmodule

// File: tb/tb_plic_gw.sv
// Directed bench for plic_gw: register map, gateway claim/complete flow, arbitration and AXI timing.
module tb_plic_gw;
  localparam int NSRC = 32;
  localparam int NCTX = 2;
  localparam int PRIO_W = 3;
  localparam logic [27:0] PEND0 = 28'h1000, TRIG0 = 28'h1080;
  localparam logic [27:0] EN0 = 28'h2000, EN1 = 28'h2080;
  localparam logic [27:0] THR0 = 28'h200000, CLM0 = 28'h200004;
  localparam logic [27:0] THR1 = 28'h201000, CLM1 = 28'h201004;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NSRC-1:0] src = '0;
  logic [NCTX-1:0] irq;
  logic [27:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rd;
  logic [1:0] bresp_l;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  plic_gw #(.NSRC(NSRC), .NCTX(NCTX), .PRIO_W(PRIO_W)) dut (
    .clk(clk), .rst_n(rst_n), .src_i(src), .irq_o(irq),
    .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
    .s_axi_wdata_i(wdata), .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
    .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
    .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
    .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rvalid_o(rvalid),
    .s_axi_rready_i(rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [27:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) check("b_timeout", 32'(bvalid), 32'd1);
    bresp_l = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [27:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) check("r_timeout", 32'(rvalid), 32'd1);
    d = rdata; rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_valids", {30'd0, rvalid, bvalid}, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    cycles(2);
    check("rst_rdata", rdata, 32'd0);
    axi_read(28'h00C, rd); check("rst_prio3", rd, 32'd0);

    // Read channel timing on a plain register read
    axi_write(28'h014, 32'd2);
    check("bresp_prio5", 32'(bresp_l), 32'd0);
    @(negedge clk); araddr = 28'h014; arvalid = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    check("ar_drop", 32'(arready), 32'd0);
    check("rvalid_n1", 32'(rvalid), 32'd1);
    check("rdata_prio5", rdata, 32'd2);
    check("rresp_ok", 32'(rresp), 32'd0);
    rready = 1'b1;
    @(posedge clk); #1; rready = 1'b0;
    check("rvalid_clr", 32'(rvalid), 32'd0);
    check("ar_back", 32'(arready), 32'd1);

    // Single source: latency, claim, hold-off, completion with level still high
    axi_write(EN0, 32'h20);
    axi_write(THR0, 32'd1);
    @(negedge clk); src[5] = 1'b1;
    @(posedge clk); #1; check("irq_lat1", 32'(irq[0]), 32'd0);
    @(posedge clk); #1; check("irq_lat2", 32'(irq[0]), 32'd1);
    axi_read(PEND0, rd); check("pend_5", rd, 32'h20);
    axi_read(CLM0, rd); check("claim_5", rd, 32'd5);
    check("irq_after_claim", 32'(irq[0]), 32'd0);
    cycles(4);
    axi_read(PEND0, rd); check("no_repend", rd, 32'h0);
    axi_write(CLM0, 32'd5);
    axi_read(PEND0, rd); check("repend_5", rd, 32'h20);
    check("irq_repend", 32'(irq[0]), 32'd1);
    axi_read(CLM0, rd); check("claim_5b", rd, 32'd5);
    @(negedge clk); src[5] = 1'b0;
    axi_write(CLM0, 32'd5);
    cycles(2);
    axi_read(PEND0, rd); check("idle_5", rd, 32'h0);

    // Arbitration: priority, lowest-ID tie-break, threshold, second context
    axi_write(28'h010, 32'd3);
    axi_write(28'h01C, 32'd3);
    axi_write(28'h024, 32'd2);
    axi_write(EN0, 32'h290);
    @(negedge clk); src[4] = 1'b1; src[7] = 1'b1; src[9] = 1'b1;
    cycles(3);
    check("irq_multi", 32'(irq[0]), 32'd1);
    axi_read(PEND0, rd); check("pend_multi", rd, 32'h290);
    axi_read(CLM0, rd); check("claim_tie", rd, 32'd4);
    axi_write(THR0, 32'd3);
    cycles(2);
    check("irq_thr3", 32'(irq[0]), 32'd0);
    axi_read(CLM0, rd); check("claim_none", rd, 32'd0);
    axi_read(PEND0, rd); check("pend_after0", rd, 32'h280);
    axi_write(EN1, 32'h200);
    cycles(2);
    check("irq1_on", 32'(irq[1]), 32'd1);
    axi_read(CLM1, rd); check("claim1_9", rd, 32'd9);
    cycles(1);
    check("irq1_off", 32'(irq[1]), 32'd0);
    axi_write(THR0, 32'd2);
    axi_read(CLM0, rd); check("claim_7", rd, 32'd7);
    axi_read(PEND0, rd); check("pend_none", rd, 32'h0);

    // Completion from another context; completion of an unclaimed source
    axi_write(CLM0, 32'd9);
    axi_read(PEND0, rd); check("cross_ctx_cmpl", rd, 32'h200);
    axi_write(CLM1, 32'd5);
    axi_read(PEND0, rd); check("stray_cmpl", rd, 32'h200);
    axi_read(CLM1, rd); check("claim1_9b", rd, 32'd9);

    // Truncation, reserved source 0, unmapped space
    axi_write(28'h008, 32'hFF);
    axi_read(28'h008, rd); check("prio_trunc", rd, 32'd7);
    axi_write(28'h000, 32'd7);
    axi_read(28'h000, rd); check("prio0_zero", rd, 32'd0);
    axi_write(EN0, 32'hFFFF_FFFF);
    axi_read(EN0, rd); check("en0_bit0", rd, 32'hFFFF_FFFE);
    axi_write(EN0, 32'h290);
    axi_write(28'h3000, 32'hFFFF_FFFF);
    check("bresp_unmapped", 32'(bresp_l), 32'd0);
    axi_read(28'h3000, rd); check("rd_unmapped", rd, 32'd0);
    axi_read(28'h014, rd); check("prio5_kept", rd, 32'd2);
    axi_read(THR1, rd); check("thr1_kept", rd, 32'd0);

`ifdef PLIC_GW_EDGE_EN
    // Edge source 6 on context 1 with deferred re-trigger
    axi_write(TRIG0, 32'h40);
    axi_read(TRIG0, rd); check("trig_rd", rd, 32'h40);
    axi_write(28'h018, 32'd1);
    axi_write(EN1, 32'h40);
    @(negedge clk); src[6] = 1'b1;
    @(posedge clk); #1; check("edge_lat1", 32'(irq[1]), 32'd0);
    @(posedge clk); #1; check("edge_lat2", 32'(irq[1]), 32'd0);
    @(posedge clk); #1; check("edge_lat3", 32'(irq[1]), 32'd1);
    @(negedge clk); src[6] = 1'b0;
    cycles(2);
    @(negedge clk); src[6] = 1'b1;
    @(negedge clk); src[6] = 1'b0;
    cycles(3);
    axi_read(CLM1, rd); check("edge_claim6", rd, 32'd6);
    axi_read(CLM1, rd); check("edge_once", rd, 32'd0);
    axi_write(CLM1, 32'd6);
    axi_read(PEND0, rd); check("edge_defer", rd & 32'h40, 32'h40);
    axi_read(CLM1, rd); check("edge_claim6b", rd, 32'd6);
    axi_write(CLM1, 32'd6);
    cycles(2);
    axi_read(PEND0, rd); check("edge_idle", rd & 32'h40, 32'h0);
    axi_read(CLM1, rd); check("edge_none", rd, 32'd0);
`else
    axi_write(TRIG0, 32'h40);
    axi_read(TRIG0, rd); check("trig_absent", rd, 32'd0);
`endif

    // Reset in the middle of a write: AW captured, W never sent
    @(negedge clk); src = '0;
    @(negedge clk); awaddr = 28'h014; awvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0;
    check("aw_captured", 32'(awready), 32'd0);
    rst_n = 1'b0;
    #2;
    check("rst_mid_bvalid", 32'(bvalid), 32'd0);
    check("rst_mid_awready", 32'(awready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    cycles(3);
    check("post_rst_bvalid", 32'(bvalid), 32'd0);
    check("post_rst_irq", 32'(irq), 32'd0);
    axi_read(28'h014, rd); check("post_rst_prio5", rd, 32'd0);
    axi_read(PEND0, rd); check("post_rst_pend", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
